// File: rtl/lab3_mem_testmemresp16b.sv
// rtl/lab3_mem_testmemresp16b.sv - blocking 16-byte-line memory responder for cache refill/evict traffic
//
// Purpose: memory-side end of a cache refill/evict interface. Accepts one
// request at a time, reads or writes a full 128-bit line in a flop-based store,
// and returns a response p_latency cycles after the accept cycle plus one.
//
// Ports:
//   clk          clock
//   reset        synchronous active-high reset (clears state and the store)
//   memreq_val   request valid
//   memreq_rdy   request ready (high only in IDLE)
//   memreq_msg   request message (type_, opaque, addr, len, data)
//   memresp_val  response valid (high only in RESP)
//   memresp_rdy  response ready
//   memresp_msg  response message (type_, opaque, test, len, data)

package lab3_mem_pkg;
    typedef struct packed {
        logic [3:0]   type_;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [3:0]   type_;
        logic [7:0]   opaque;
        logic [1:0]   test;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_resp_16B_t;

    localparam logic [3:0] MEM_READ  = 4'd0;
    localparam logic [3:0] MEM_WRITE = 4'd1;
    localparam logic [3:0] MEM_INIT  = 4'd2;
endpackage

module lab3_mem_testmemresp16b
    import lab3_mem_pkg::*;
#(
    parameter int p_num_entries = 256,
    parameter int p_latency     = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memreq_val,
    output logic          memreq_rdy,
    input  mem_req_16B_t  memreq_msg,
    output logic          memresp_val,
    input  logic          memresp_rdy,
    output mem_resp_16B_t memresp_msg
);

    localparam int IW = $clog2(p_num_entries);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    mem_resp_16B_t resp_q, resp_d;
    logic [127:0]  store_q [p_num_entries];

    logic          store_we;
    logic [IW-1:0] idx;

    // Line index; offset bits and high address bits alias away.
    assign idx = memreq_msg.addr[4 +: IW];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{memreq_msg.addr[3:0], memreq_msg.addr[31:4+IW]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        resp_d      = resp_q;
        store_we    = 1'b0;
        memreq_rdy  = 1'b0;
        memresp_val = 1'b0;

        case (state_q)
            IDLE: begin
                memreq_rdy = 1'b1;
                if (memreq_val) begin
                    resp_d.type_  = memreq_msg.type_;
                    resp_d.opaque = memreq_msg.opaque;
                    resp_d.len    = memreq_msg.len;
                    resp_d.test   = 2'b00;
                    resp_d.data   = '0;
                    case (memreq_msg.type_)
                        MEM_READ:            resp_d.data = store_q[idx];
                        MEM_WRITE, MEM_INIT: store_we    = 1'b1;
                        default:             resp_d.test = 2'b11;
                    endcase
                    if (p_latency > 0) begin
                        state_d = WAIT;
                        cnt_d   = 4'(p_latency);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                memresp_val = 1'b1;
                if (memresp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
        end
    end

    // Store kept in its own block: full-line writes happen on the accept edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < p_num_entries; i++) begin
                store_q[i] <= '0;
            end
        end else if (store_we) begin
            store_q[idx] <= memreq_msg.data;
        end
    end

    assign memresp_msg = resp_q;

endmodule

// File: tb/tb_lab3_mem_testmemresp16b.sv
// tb/tb_lab3_mem_testmemresp16b.sv - directed self-checking bench for lab3_mem_testmemresp16b
module tb_lab3_mem_testmemresp16b;
    import lab3_mem_pkg::*;

    logic          clk;
    logic          reset;

    logic          req_val, req_rdy, resp_val, resp_rdy;
    mem_req_16B_t  req_msg;
    mem_resp_16B_t resp_msg;

    logic          req_val0, req_rdy0, resp_val0, resp_rdy0;
    mem_req_16B_t  req_msg0;
    mem_resp_16B_t resp_msg0;

    int checks = 0;
    int errors = 0;

    lab3_mem_testmemresp16b #(.p_num_entries(256), .p_latency(2)) dut (
        .clk(clk), .reset(reset),
        .memreq_val(req_val), .memreq_rdy(req_rdy), .memreq_msg(req_msg),
        .memresp_val(resp_val), .memresp_rdy(resp_rdy), .memresp_msg(resp_msg)
    );

    lab3_mem_testmemresp16b #(.p_num_entries(256), .p_latency(0)) dut0 (
        .clk(clk), .reset(reset),
        .memreq_val(req_val0), .memreq_rdy(req_rdy0), .memreq_msg(req_msg0),
        .memresp_val(resp_val0), .memresp_rdy(resp_rdy0), .memresp_msg(resp_msg0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic mem_req_16B_t mk(input logic [3:0] t, input logic [7:0] op,
                                        input logic [31:0] a, input logic [127:0] d);
        mem_req_16B_t m;
        m.type_ = t; m.opaque = op; m.addr = a; m.len = 4'd0; m.data = d;
        return m;
    endfunction

    // Present a request on dut at a negedge; returns once it will be accepted on the next posedge.
    task automatic send(input mem_req_16B_t m);
        int n = 0;
        req_msg = m;
        req_val = 1'b1;
        while (!req_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_rdy", {127'b0, req_rdy}, 128'd1);
        @(posedge clk);
        @(negedge clk);
        req_val = 1'b0;
        req_msg = 'x;
    endtask

    // Called one negedge after accept; counts further negedges until resp valid.
    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_val && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    localparam logic [127:0] LINE_A = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    localparam logic [127:0] LINE_B = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

    initial begin
        int lat;
        mem_resp_16B_t snap;

        reset = 1'b1;
        req_val = 1'b0; req_msg = 'x; resp_rdy = 1'b1;
        req_val0 = 1'b0; req_msg0 = '0; resp_rdy0 = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // reset state
        check("rst_req_rdy", {127'b0, req_rdy}, 128'd1);
        check("rst_resp_val", {127'b0, resp_val}, 128'd0);
        check("rst_resp_msg", resp_msg.data ^ {112'b0, resp_msg.type_, resp_msg.opaque, resp_msg.test, resp_msg.len}, 128'd0);

        // 1: read of cleared store, latency t+3
        send(mk(MEM_READ, 8'h11, 32'h0000_0040, '0));
        wait_resp(lat);
        check("t1_latency", 128'(lat), 128'd3);
        check("t1_data", resp_msg.data, 128'h0);
        check("t1_type", 128'(resp_msg.type_), 128'd0);
        check("t1_test", 128'(resp_msg.test), 128'd0);
        check("t1_opaque", 128'(resp_msg.opaque), 128'h11);
        @(negedge clk);

        // 2: write then read with nonzero offset
        send(mk(MEM_WRITE, 8'h5A, 32'h0000_0100, LINE_A));
        wait_resp(lat);
        check("t2_wr_data", resp_msg.data, 128'h0);
        check("t2_wr_opaque", 128'(resp_msg.opaque), 128'h5A);
        check("t2_wr_type", 128'(resp_msg.type_), 128'd1);
        @(negedge clk);
        send(mk(MEM_READ, 8'h5B, 32'h0000_0108, '0));
        wait_resp(lat);
        check("t2_rd_data", resp_msg.data, LINE_A);
        @(negedge clk);

        // 3: INIT at aliasing address, read idx 0
        send(mk(MEM_INIT, 8'h01, 32'h0000_1000, 128'h1));
        wait_resp(lat);
        check("t3_init_type", 128'(resp_msg.type_), 128'd2);
        @(negedge clk);
        send(mk(MEM_READ, 8'h02, 32'h0000_0000, '0));
        wait_resp(lat);
        check("t3_alias", resp_msg.data, 128'h1);
        @(negedge clk);

        // unsupported type: test=11, store untouched
        send(mk(4'd7, 8'h33, 32'h0000_0100, LINE_B));
        wait_resp(lat);
        check("bad_test", 128'(resp_msg.test), 128'd3);
        check("bad_data", resp_msg.data, 128'h0);
        @(negedge clk);
        send(mk(MEM_READ, 8'h34, 32'h0000_0100, '0));
        wait_resp(lat);
        check("bad_nowrite", resp_msg.data, LINE_A);
        @(negedge clk);

        // 4: backpressure
        resp_rdy = 1'b0;
        send(mk(MEM_READ, 8'h44, 32'h0000_0100, '0));
        wait_resp(lat);
        snap = resp_msg;
        req_msg = mk(MEM_READ, 8'h45, 32'h0000_0000, '0);
        req_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_val_hold", {127'b0, resp_val}, 128'd1);
            check("t4_req_rdy", {127'b0, req_rdy}, 128'd0);
            check("t4_msg_stable", resp_msg.data ^ {112'b0, resp_msg.type_, resp_msg.opaque, resp_msg.test, resp_msg.len},
                  snap.data ^ {112'b0, snap.type_, snap.opaque, snap.test, snap.len});
        end
        resp_rdy = 1'b1;
        @(negedge clk);
        check("t4_req_rdy_after", {127'b0, req_rdy}, 128'd1);
        check("t4_resp_val_low", {127'b0, resp_val}, 128'd0);
        @(negedge clk);
        req_val = 1'b0; req_msg = 'x;
        check("t4_second_accepted", {127'b0, req_rdy}, 128'd0);
        wait_resp(lat);
        check("t4_second_opaque", 128'(resp_msg.opaque), 128'h45);
        check("t4_second_data", resp_msg.data, 128'h1);
        @(negedge clk);

        // 5: p_latency=0 back-to-back, val held high
        req_msg0 = mk(MEM_WRITE, 8'h50, 32'h0000_0020, LINE_B);
        req_val0 = 1'b1;
        check("t5_rdy_t", {127'b0, req_rdy0}, 128'd1);
        @(negedge clk);
        check("t5_wr_resp", {127'b0, resp_val0}, 128'd1);
        check("t5_wr_type", 128'(resp_msg0.type_), 128'd1);
        check("t5_rdy_t1", {127'b0, req_rdy0}, 128'd0);
        req_msg0 = mk(MEM_READ, 8'h51, 32'h0000_0020, '0);
        @(negedge clk);
        check("t5_rdy_t2", {127'b0, req_rdy0}, 128'd1);
        check("t5_val_t2", {127'b0, resp_val0}, 128'd0);
        @(negedge clk);
        req_val0 = 1'b0;
        check("t5_rd_resp", {127'b0, resp_val0}, 128'd1);
        check("t5_rd_data", resp_msg0.data, LINE_B);
        @(negedge clk);

        // 6: reset during WAIT
        req_msg = mk(MEM_WRITE, 8'h60, 32'h0000_0030, LINE_A);
        req_val = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_val = 1'b0; req_msg = 'x;
        check("t6_in_wait", {127'b0, req_rdy}, 128'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_val_after_rst", {127'b0, resp_val}, 128'd0);
        check("t6_rdy_after_rst", {127'b0, req_rdy}, 128'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_no_resp", {127'b0, resp_val}, 128'd0);
        end
        send(mk(MEM_READ, 8'h61, 32'h0000_0030, '0));
        wait_resp(lat);
        check("t6_rd_valid", {127'b0, resp_val}, 128'd1);
        check("t6_rd_data", resp_msg.data, 128'h0);
        @(negedge clk);
        send(mk(MEM_READ, 8'h62, 32'h0000_0100, '0));
        wait_resp(lat);
        check("t6_store_cleared", resp_msg.data, 128'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
